// File: rtl/axi_ram_slave.sv
// AXI4 memory slave: word-addressed on-chip RAM behind AW/W/B and AR/R channels.
// One outstanding write and one outstanding read, handled by independent FSMs.
// FIXED, INCR and WRAP bursts of 32-bit beats with byte strobes; bad requests
// are still fully handshaken but answered with SLVERR.
module axi_ram_slave #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MEM_DEPTH_LOG2 = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXI_ID_WIDTH-1:0]     axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [7:0]                  axi_awlen,
    input  logic [2:0]                  axi_awsize,
    input  logic [1:0]                  axi_awburst,
    input  logic                        axi_awvalid,
    output logic                        axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                        axi_wlast,
    input  logic                        axi_wvalid,
    output logic                        axi_wready,
    output logic [AXI_ID_WIDTH-1:0]     axi_bid,
    output logic [1:0]                  axi_bresp,
    output logic                        axi_bvalid,
    input  logic                        axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]     axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [7:0]                  axi_arlen,
    input  logic [2:0]                  axi_arsize,
    input  logic [1:0]                  axi_arburst,
    input  logic                        axi_arvalid,
    output logic                        axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]                  axi_rresp,
    output logic                        axi_rlast,
    output logic                        axi_rvalid,
    input  logic                        axi_rready
);

    localparam int         MEM_DEPTH   = 1 << MEM_DEPTH_LOG2;
    localparam int         STRB_W      = AXI_DATA_WIDTH / 8;
    localparam int         IDX_HI      = MEM_DEPTH_LOG2 + 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    // Address of the following beat. For WRAP, len*4+3 is the byte mask of the
    // (len+1)*4 block whenever len is one of the legal wrap lengths.
    function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(
        input logic [AXI_ADDR_WIDTH-1:0] a,
        input logic [1:0]                burst,
        input logic [7:0]                len
    );
        logic [AXI_ADDR_WIDTH-1:0] mask;
        logic [AXI_ADDR_WIDTH-1:0] inc;
        logic [AXI_ADDR_WIDTH-1:0] res;
        mask = {{(AXI_ADDR_WIDTH-10){1'b0}}, len, 2'b11};
        inc  = a + {{(AXI_ADDR_WIDTH-3){1'b0}}, 3'b100};
        case (burst)
            2'b01:   res = inc;
            2'b10:   res = (a & ~mask) | (inc & mask);
            default: res = a;
        endcase
        return res;
    endfunction

    // Requests this slave cannot serve: non-32-bit beats, reserved burst type,
    // or a WRAP length outside 2/4/8/16 beats.
    function automatic logic bad_req(
        input logic [2:0] size,
        input logic [1:0] burst,
        input logic [7:0] len
    );
        logic wrap_ok;
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size != 3'b010) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok);
    endfunction

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    wstate_t                   w_state, w_next;
    logic                      aw_hs, w_beat;
    logic [AXI_ADDR_WIDTH-1:0] waddr;
    logic [7:0]                wlen, wcnt;
    logic [1:0]                wburst;
    logic [AXI_ID_WIDTH-1:0]   wid;
    logic                      werr;

    rstate_t                   r_state, r_next;
    logic                      ar_hs, r_beat;
    logic [AXI_ADDR_WIDTH-1:0] raddr, raddr_nxt;
    logic [7:0]                rlen, rcnt;
    logic [1:0]                rburst;
    logic                      rerr;

    // Write FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    // Write FSM next state and handshake decode; the last beat is len+1 or any wlast.
    always_comb begin
        w_next = w_state;
        aw_hs  = 1'b0;
        w_beat = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_hs = axi_awvalid && axi_awready;
                if (aw_hs) w_next = W_DATA;
            end
            W_DATA: begin
                w_beat = axi_wvalid && axi_wready;
                if (w_beat && (axi_wlast || (wcnt == wlen))) w_next = W_RESP;
            end
            W_RESP: begin
                if (axi_bvalid && axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write channel registers: outputs follow the next state, burst context advances per beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b0;
            axi_bresp   <= RESP_OKAY;
            axi_bid     <= '0;
            waddr       <= '0;
            wlen        <= '0;
            wcnt        <= '0;
            wburst      <= '0;
            wid         <= '0;
            werr        <= 1'b0;
        end else begin
            axi_awready <= (w_next == W_IDLE);
            axi_wready  <= (w_next == W_DATA);
            axi_bvalid  <= (w_next == W_RESP);
            if (aw_hs) begin
                waddr  <= axi_awaddr;
                wlen   <= axi_awlen;
                wburst <= axi_awburst;
                wid    <= axi_awid;
                wcnt   <= '0;
                werr   <= bad_req(axi_awsize, axi_awburst, axi_awlen);
            end
            if (w_beat) begin
                waddr <= next_addr(waddr, wburst, wlen);
                wcnt  <= wcnt + 8'd1;
            end
            // A final beat whose wlast disagrees with the count is an early or missing wlast.
            if (w_beat && (w_next == W_RESP)) begin
                axi_bresp <= (werr || (axi_wlast != (wcnt == wlen))) ? RESP_SLVERR : RESP_OKAY;
                axi_bid   <= wid;
            end
        end
    end

    // RAM write port with byte strobes; contents are deliberately not reset.
    always_ff @(posedge aclk) begin
        if (w_beat && !werr) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_wstrb[b]) mem[waddr[IDX_HI:2]][8*b +: 8] <= axi_wdata[8*b +: 8];
            end
        end
    end

    assign raddr_nxt = next_addr(raddr, rburst, rlen);

    // Read FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // Read FSM next state and handshake decode.
    always_comb begin
        r_next = r_state;
        ar_hs  = 1'b0;
        r_beat = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_hs = axi_arvalid && axi_arready;
                if (ar_hs) r_next = R_DATA;
            end
            R_DATA: begin
                r_beat = axi_rvalid && axi_rready;
                if (r_beat && (rcnt == rlen)) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read channel registers: the next word is fetched on the accepting edge so beats stream back-to-back.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b0;
            axi_rlast   <= 1'b0;
            axi_rresp   <= RESP_OKAY;
            axi_rdata   <= '0;
            axi_rid     <= '0;
            raddr       <= '0;
            rlen        <= '0;
            rcnt        <= '0;
            rburst      <= '0;
            rerr        <= 1'b0;
        end else begin
            axi_arready <= (r_next == R_IDLE);
            axi_rvalid  <= (r_next == R_DATA);
            if (ar_hs) begin
                raddr     <= axi_araddr;
                rlen      <= axi_arlen;
                rburst    <= axi_arburst;
                rcnt      <= '0;
                rerr      <= bad_req(axi_arsize, axi_arburst, axi_arlen);
                axi_rid   <= axi_arid;
                axi_rlast <= (axi_arlen == 8'd0);
                axi_rresp <= bad_req(axi_arsize, axi_arburst, axi_arlen) ? RESP_SLVERR : RESP_OKAY;
                axi_rdata <= bad_req(axi_arsize, axi_arburst, axi_arlen) ? '0 : mem[axi_araddr[IDX_HI:2]];
            end else if (r_beat) begin
                if (r_next == R_IDLE) begin
                    axi_rlast <= 1'b0;
                end else begin
                    raddr     <= raddr_nxt;
                    rcnt      <= rcnt + 8'd1;
                    axi_rlast <= ((rcnt + 8'd1) == rlen);
                    axi_rdata <= rerr ? '0 : mem[raddr_nxt[IDX_HI:2]];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Testbench for axi_ram_slave: directed and randomized bursts checked against
// a word-array memory model with closed-form burst address arithmetic.
module tb_axi_ram_slave;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [0:0]  axi_awid;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [0:0]  axi_bid;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [0:0]  axi_arid;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [0:0]  axi_rid;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready;

    always #5 aclk = ~aclk;

    axi_ram_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] ref_mem [256];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst, input int len);
        return (size != 3'd2) || (burst == 2'd3) || ((burst == 2'd2) && !(len inside {1, 3, 7, 15}));
    endfunction

    // RAM word touched by beat i of a burst, straight from the burst-type rules.
    function automatic int model_word(input logic [31:0] a, input logic [1:0] burst, input int len, input int i);
        logic [31:0] b, blk, base;
        case (burst)
            2'd1: b = a + 32'(4 * i);
            2'd2: begin
                blk  = 32'((len + 1) * 4);
                base = a - (a % blk);
                b    = base + ((a - base + 32'(4 * i)) % blk);
            end
            default: b = a;
        endcase
        return int'((b >> 2) & 32'hFF);
    endfunction

    task automatic do_write(input logic [0:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int last_at, input int bdelay);
        int nb, cyc, w;
        logic err;
        logic [1:0] exp_resp;
        err      = req_err(size, burst, len);
        exp_resp = (err || last_at != len) ? 2'b10 : 2'b00;
        nb       = (last_at < len) ? last_at + 1 : len + 1;
        axi_awid = id; axi_awaddr = addr; axi_awlen = 8'(len);
        axi_awsize = size; axi_awburst = burst; axi_awvalid = 1'b1;
        cyc = 0;
        while (!axi_awready && cyc < 50) begin @(posedge aclk); #1; cyc++; end
        check_val("aw_wait", 64'(cyc < 50), 64'd1);
        @(posedge aclk); #1;
        axi_awvalid = 1'b0;
        check_val("aw_to_w", {axi_awready, axi_wready}, 2'b01);
        for (int i = 0; i < nb; i++) begin
            axi_wdata = wd[i]; axi_wstrb = ws[i]; axi_wlast = (i == last_at); axi_wvalid = 1'b1;
            cyc = 0;
            while (!axi_wready && cyc < 50) begin @(posedge aclk); #1; cyc++; end
            @(posedge aclk); #1;
            if (!err) begin
                w = model_word(addr, burst, len, i);
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) ref_mem[w][8*b +: 8] = wd[i][8*b +: 8];
            end
        end
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
        check_val("w_to_b", {axi_wready, axi_bvalid}, 2'b01);
        for (int d = 0; d < bdelay; d++) begin
            check_val("b_hold", {axi_bvalid, axi_bresp, axi_bid}, {1'b1, exp_resp, id});
            @(posedge aclk); #1;
        end
        check_val("bresp", {axi_bvalid, axi_bresp, axi_bid}, {1'b1, exp_resp, id});
        axi_bready = 1'b1;
        @(posedge aclk); #1;
        axi_bready = 1'b0;
        check_val("b_to_aw", {axi_bvalid, axi_awready}, 2'b01);
    endtask

    // mode 0: rready held high, 1: toggling from a stalled first cycle, 2: random.
    task automatic do_read(input logic [0:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode,
                           output logic [31:0] first);
        int cyc, i;
        logic err;
        logic [1:0]  eresp;
        logic [31:0] ed;
        err   = req_err(size, burst, len);
        eresp = err ? 2'b10 : 2'b00;
        first = 32'hDEAD_BEEF;
        axi_arid = id; axi_araddr = addr; axi_arlen = 8'(len);
        axi_arsize = size; axi_arburst = burst; axi_arvalid = 1'b1;
        cyc = 0;
        while (!axi_arready && cyc < 50) begin @(posedge aclk); #1; cyc++; end
        check_val("ar_wait", 64'(cyc < 50), 64'd1);
        @(posedge aclk); #1;
        axi_arvalid = 1'b0;
        check_val("ar_to_r", {axi_arready, axi_rvalid}, 2'b01);
        i = 0; cyc = 0;
        while (i <= len && cyc < 400) begin
            case (mode)
                0:       axi_rready = 1'b1;
                1:       axi_rready = cyc[0];
                default: axi_rready = 1'($urandom_range(0, 1));
            endcase
            ed = err ? 32'd0 : ref_mem[model_word(addr, burst, len, i)];
            check_val("r_beat", {axi_rvalid, axi_rresp, axi_rlast, axi_rid, axi_rdata},
                      {1'b1, eresp, (i == len), id, ed});
            if (i == 0) first = axi_rdata;
            if (axi_rready) i++;
            @(posedge aclk); #1;
            cyc++;
        end
        axi_rready = 1'b0;
        check_val("r_count", 64'(i), 64'(len + 1));
        check_val("r_to_ar", {axi_rvalid, axi_arready}, 2'b01);
    endtask

    task automatic fill_random(input int n, input logic full_strb);
        for (int i = 0; i < n; i++) begin
            wd[i] = $urandom;
            ws[i] = full_strb ? 4'hF : 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd0;
        logic [1:0]  bt;
        int          len, last_at;
        logic [2:0]  sz;

        aresetn = 1'b0;
        axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0; axi_awvalid = 1'b0;
        axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b0;
        axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arsize = '0; axi_arburst = '0; axi_arvalid = 1'b0;
        axi_rready = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        check_val("reset_outs", {axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_bid, axi_arready,
                                 axi_rvalid, axi_rlast, axi_rresp, axi_rid, axi_rdata}, 64'd0);
        #2 aresetn = 1'b1;
        #1 check_val("ready_pre_edge", {axi_awready, axi_arready}, 2'b00);
        @(posedge aclk); #1;
        check_val("ready_after_rel", {axi_awready, axi_arready}, 2'b11);

        // INCR round trip through the aliased upper address, then fill the rest of the RAM.
        fill_random(32, 1'b1);
        wd[0] = 32'h6434_3962; wd[31] = 32'h0002_0000;
        do_write(1'b1, 32'h8000_0000, 31, 3'd2, 2'd1, 31, 0);
        for (int k = 1; k < 8; k++) begin
            fill_random(32, 1'b1);
            do_write(1'b0, 32'(k * 128), 31, 3'd2, 2'd1, 31, 0);
        end
        do_read(1'b0, 32'h0000_0000, 31, 3'd2, 2'd1, 0, rd0);
        check_val("incr_first_word", rd0, 32'h6434_3962);

        // WRAP len=3 starting at word 3.
        wd[0] = 32'hAAAA_0001; wd[1] = 32'hBBBB_0002; wd[2] = 32'hCCCC_0003; wd[3] = 32'hDDDD_0004;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(1'b1, 32'h0000_000C, 3, 3'd2, 2'd2, 3, 0);
        do_read(1'b1, 32'h0000_000C, 3, 3'd2, 2'd2, 0, rd0);
        check_val("wrap_first", rd0, 32'hAAAA_0001);
        do_read(1'b0, 32'h0000_0000, 3, 3'd2, 2'd1, 0, rd0);
        check_val("wrap_word0", rd0, 32'hBBBB_0002);

        // FIXED burst keeps the last beat; partial strobes merge.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(1'b0, 32'h0000_0010, 3, 3'd2, 2'd0, 3, 0);
        do_read(1'b0, 32'h0000_0010, 0, 3'd2, 2'd1, 0, rd0);
        check_val("fixed_last", rd0, 32'd4);
        wd[0] = 32'h1234_5678; ws[0] = 4'hF;
        do_write(1'b0, 32'h0000_0020, 0, 3'd2, 2'd1, 0, 0);
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'b0011;
        do_write(1'b0, 32'h0000_0020, 0, 3'd2, 2'd1, 0, 0);
        do_read(1'b0, 32'h0000_0020, 0, 3'd2, 2'd1, 0, rd0);
        check_val("strobe_merge", rd0, 32'h1234_FFFF);

        // Error responses: bad size, early wlast, missing wlast, reserved burst, bad wrap length.
        fill_random(4, 1'b1);
        do_write(1'b1, 32'h0000_0040, 3, 3'd3, 2'd1, 3, 0);
        do_read(1'b0, 32'h0000_0040, 3, 3'd2, 2'd1, 0, rd0);
        fill_random(4, 1'b1);
        do_write(1'b0, 32'h0000_0080, 3, 3'd2, 2'd1, 1, 0);
        do_read(1'b0, 32'h0000_0080, 3, 3'd2, 2'd1, 0, rd0);
        fill_random(4, 1'b1);
        do_write(1'b1, 32'h0000_00C0, 3, 3'd2, 2'd1, 9, 0);
        do_read(1'b0, 32'h0000_00C0, 3, 3'd2, 2'd1, 0, rd0);
        do_read(1'b1, 32'h0000_0100, 1, 3'd2, 2'd3, 0, rd0);
        check_val("err_read_data", rd0, 32'd0);
        do_read(1'b0, 32'h0000_0100, 2, 3'd2, 2'd2, 0, rd0);

        // Backpressure on both response paths.
        fill_random(8, 1'b1);
        do_write(1'b1, 32'h0000_0140, 7, 3'd2, 2'd1, 7, 5);
        do_read(1'b1, 32'h0000_0140, 7, 3'd2, 2'd1, 1, rd0);

        // Reset while a write and a read are both mid-burst.
        axi_awid = 1'b1; axi_awaddr = 32'h0000_0200; axi_awlen = 8'd7; axi_awsize = 3'd2; axi_awburst = 2'd1;
        axi_arid = 1'b1; axi_araddr = 32'h0000_0300; axi_arlen = 8'd7; axi_arsize = 3'd2; axi_arburst = 2'd1;
        axi_awvalid = 1'b1; axi_arvalid = 1'b1;
        @(posedge aclk); #1;
        axi_awvalid = 1'b0; axi_arvalid = 1'b0;
        check_val("mid_busy", {axi_wready, axi_rvalid}, 2'b11);
        for (int i = 0; i < 2; i++) begin
            axi_wdata = $urandom; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
            ref_mem[128 + i] = axi_wdata;
            @(posedge aclk); #1;
        end
        axi_wvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        check_val("mid_reset_outs", {axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_bid, axi_arready,
                                     axi_rvalid, axi_rlast, axi_rresp, axi_rid, axi_rdata}, 64'd0);
        @(posedge aclk); #2;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check_val("mid_ready_rel", {axi_awready, axi_arready, axi_wready, axi_rvalid}, 4'b1100);
        do_read(1'b0, 32'h0000_0200, 7, 3'd2, 2'd1, 0, rd0);
        do_read(1'b0, 32'h0000_0000, 15, 3'd2, 2'd1, 2, rd0);

        // Randomized traffic, each write read back with the same burst parameters.
        for (int t = 0; t < 25; t++) begin
            bt = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) bt = 2'd3;
            if (bt == 2'd2) begin
                case ($urandom_range(0, 4))
                    0: len = 1;
                    1: len = 3;
                    2: len = 7;
                    3: len = 15;
                    default: len = 5;
                endcase
            end else begin
                len = $urandom_range(0, 15);
            end
            sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'd2;
            last_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len + 1) : len;
            fill_random(len + 1, 1'b0);
            do_write(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, len, sz, bt, last_at,
                     $urandom_range(0, 3));
            do_read(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, len, sz, bt,
                    $urandom_range(0, 2), rd0);
            do_read(1'b0, 32'(model_word(32'h0, 2'd0, 0, 0)), 0, 3'd2, 2'd1, 0, rd0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
